// File: rtl/load_store_unit.sv
// Memory-stage load/store engine: single-outstanding req/ready data port,
// byte-lane steering, load extension, misalignment and bus-timeout faults.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [1:0]  MemSizeM,
  input  logic        MemUnsignedM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignedM,
  output logic        AccessFaultM
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TMO_EN ? TIMEOUT - 1 : 0);

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             is_load;
  logic             misaligned;
  logic             issue;
  logic             done;
  logic             fault_set;
  logic             tmo;
  logic [31:0]      st_wdata;
  logic [3:0]       st_wstrb;
  logic [1:0]       size_q;
  logic [1:0]       off_q;
  logic             uns_q;
  logic             load_q;
  logic             fault_q;
  logic [31:0]      ld_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;

  // A simultaneous read+write is handled as a load.
  assign access  = MemReadM | MemWriteM;
  assign is_load = MemReadM;

  // Alignment check on the M-stage address; bytes never fault.
  always_comb begin
    misaligned = 1'b0;
    unique case (MemSizeM)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ALUResultM[0];
      default: misaligned = |ALUResultM[1:0];
    endcase
  end

  // Store lane replication and write strobes.
  always_comb begin
    st_wdata = WriteDataM;
    st_wstrb = 4'b1111;
    unique case (MemSizeM)
      2'b00: begin
        st_wdata = {4{WriteDataM[7:0]}};
        st_wstrb = 4'b0001 << ALUResultM[1:0];
      end
      2'b01: begin
        st_wdata = {2{WriteDataM[15:0]}};
        st_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = WriteDataM;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  // Load extraction uses only the offset/size latched at issue.
  assign ld_byte = dmem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // Sign/zero extension of the selected lane.
  always_comb begin
    ld_data = dmem_rdata;
    unique case (size_q)
      2'b00:   ld_data = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
      2'b01:   ld_data = {{16{ld_half[15] & ~uns_q}}, ld_half};
      default: ld_data = dmem_rdata;
    endcase
  end

  assign tmo = TMO_EN && (cnt == TMO_LAST);

  // Next-state logic; ready wins over a coincident timeout.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    done      = 1'b0;
    fault_set = 1'b0;
    unique case (state)
      IDLE: begin
        if (access && !misaligned) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (dmem_ready) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if (tmo) begin
          fault_set = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stall and misalignment are gated by reset so they drop at once.
  always_comb begin
    StallM      = 1'b0;
    MisalignedM = 1'b0;
    if (!rst) begin
      StallM      = (state == WAIT) ||
                    ((state == IDLE) && access && !misaligned);
      MisalignedM = (state == IDLE) && access && misaligned;
    end
  end

  assign AccessFaultM = fault_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Timeout counter runs only while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == WAIT) cnt <= cnt + 1'b1;
    else                    cnt <= '0;
  end

  // Bus request and its payload, held stable while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= '0;
    end else if (issue) begin
      dmem_req   <= 1'b1;
      dmem_we    <= MemWriteM & ~MemReadM;
      dmem_addr  <= {ALUResultM[31:2], 2'b00};
      dmem_wdata <= st_wdata;
      dmem_wstrb <= is_load ? 4'b0000 : st_wstrb;
    end else if (done || fault_set) begin
      dmem_req   <= 1'b0;
    end
  end

  // Access attributes needed when the response arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      size_q <= '0;
      off_q  <= '0;
      uns_q  <= 1'b0;
      load_q <= 1'b0;
    end else if (issue) begin
      size_q <= MemSizeM;
      off_q  <= ALUResultM[1:0];
      uns_q  <= MemUnsignedM;
      load_q <= is_load;
    end
  end

  // Load result register and one-cycle fault pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ReadDataM <= '0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= fault_set;
      if (done && load_q) ReadDataM <= ld_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a behavioural model
// of lane steering, extension, latency and timeout.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWriteM, MemReadM, MemUnsignedM;
  logic [1:0]  MemSizeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] ReadDataM;
  logic        StallM, MisalignedM, AccessFaultM;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd_exp;

  load_store_unit #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .MemSizeM(MemSizeM), .MemUnsignedM(MemUnsignedM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .ReadDataM(ReadDataM),
    .StallM(StallM), .MisalignedM(MisalignedM),
    .AccessFaultM(AccessFaultM)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit m_misal(input int sz, input logic [31:0] a);
    if (sz == 0) return 1'b0;
    if (sz == 1) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input bit uns,
      input logic [31:0] a, input logic [31:0] w);
    longint v;
    int sh;
    sh = int'(a % 4) * 8;
    if (sz == 0) begin
      v = longint'((w >> sh) & 32'hFF);
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = longint'((w >> sh) & 32'hFFFF);
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int sz,
      input logic [31:0] d);
    if (sz == 0) return (d & 32'hFF) * 32'h01010101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_wstrb(input int sz,
      input logic [31:0] a);
    if (sz == 0) return 32'd1 << (a % 4);
    if (sz == 1) return 32'd3 << (a % 4);
    return 32'd15;
  endfunction

  // One access; lat = WAIT cycle on which ready is given (0 = never).
  task automatic access(input bit wr, input bit rd, input int sz,
      input bit uns, input logic [31:0] a, input logic [31:0] wd,
      input int lat, input logic [31:0] rdat);
    int stalls, w, exp_st;
    bit mis, fault_exp;
    @(negedge clk);
    MemWriteM    = wr;
    MemReadM     = rd;
    MemSizeM     = sz[1:0];
    MemUnsignedM = uns;
    ALUResultM   = a;
    WriteDataM   = wd;
    dmem_ready   = 1'b0;
    #1;
    mis = m_misal(sz, a);
    check("misal", MisalignedM, mis);
    check("stall_idle", StallM, !mis);
    if (mis) begin
      @(posedge clk);
      #1;
      check("misal_noreq", dmem_req, 0);
      check("misal_nofault", AccessFaultM, 0);
      MemReadM  = 1'b0;
      MemWriteM = 1'b0;
      return;
    end
    stalls = 1;
    w = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!StallM) break;
      stalls++;
      w++;
      check("req", dmem_req, 1);
      check("addr", dmem_addr, a & 32'hFFFF_FFFC);
      check("we", dmem_we, wr && !rd);
      check("wstrb", dmem_wstrb, rd ? 32'd0 : m_wstrb(sz, a));
      if (!rd) check("wdata", dmem_wdata, m_wdata(sz, wd));
      ALUResultM = $urandom;
      WriteDataM = $urandom;
      if (w == lat) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdat;
      end else begin
        dmem_ready = 1'b0;
        dmem_rdata = $urandom;
      end
    end
    fault_exp = !(lat >= 1 && lat <= TO);
    exp_st = fault_exp ? TO + 1 : lat + 1;
    if (rd && !fault_exp) rd_exp = m_load(sz, uns, a, rdat);
    check("stall_cycles", stalls, exp_st);
    check("resp_stall", StallM, 0);
    check("resp_req", dmem_req, 0);
    check("resp_fault", AccessFaultM, fault_exp);
    check("resp_misal", MisalignedM, 0);
    check("rdata", ReadDataM, rd_exp);
    dmem_ready = 1'b0;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    @(negedge clk);
    check("fault_pulse", AccessFaultM, 0);
    check("idle_req", dmem_req, 0);
  endtask

  initial begin
    int sz, lat, pick;
    bit wr, rd;
    logic [31:0] a;
    rst = 1'b1;
    MemWriteM = 0; MemReadM = 0; MemSizeM = 0; MemUnsignedM = 0;
    ALUResultM = 0; WriteDataM = 0; dmem_ready = 0; dmem_rdata = 0;
    rd_exp = 0;
    repeat (3) @(negedge clk);
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_wdata", dmem_wdata, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_fault", AccessFaultM, 0);
    check("rst_stall", StallM, 0);
    rst = 1'b0;

    access(0, 1, 0, 0, 32'h1002, 0, 1, 32'h80FF7F00);
    check("lb", ReadDataM, 32'hFFFFFFFF);
    access(0, 1, 0, 1, 32'h1002, 0, 1, 32'h80FF7F00);
    check("lbu", ReadDataM, 32'h000000FF);
    access(0, 1, 1, 1, 32'h2002, 0, 1, 32'hBEEF1234);
    check("lhu", ReadDataM, 32'h0000BEEF);
    access(0, 1, 1, 0, 32'h2002, 0, 1, 32'hBEEF1234);
    check("lh", ReadDataM, 32'hFFFFBEEF);
    access(1, 0, 0, 0, 32'h3003, 32'h000000A5, 1, 0);
    access(1, 0, 1, 0, 32'h3002, 32'h1234ABCD, 2, 0);
    access(0, 1, 2, 0, 32'h4002, 0, 1, 0);
    access(0, 1, 2, 0, 32'h4000, 0, 1, 32'h13579BDF);
    access(0, 1, 2, 0, 32'h4004, 0, 0, 32'h0);
    check("tmo_keep", ReadDataM, 32'h13579BDF);
    access(0, 1, 2, 0, 32'h4008, 0, TO, 32'hCAFEF00D);
    access(1, 1, 0, 1, 32'h4101, 32'hFF, 1, 32'h0000EE00);

    // Reset while waiting drops the request immediately.
    @(negedge clk);
    MemReadM = 1; MemSizeM = 2; ALUResultM = 32'h5000;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_req", dmem_req, 0);
    check("midrst_stall", StallM, 0);
    check("midrst_rdata", ReadDataM, 0);
    rd_exp = 0;
    @(negedge clk);
    rst = 1'b0;
    MemReadM = 0;
    access(1, 0, 2, 0, 32'h5004, 32'hDEADBEEF, 1, 0);
    access(0, 1, 2, 0, 32'h5008, 0, 1, 32'h89ABCDEF);
    access(1, 0, 2, 0, 32'h500C, 32'h01020304, 1, 0);

    for (int i = 0; i < 150; i++) begin
      sz = $urandom_range(0, 3);
      pick = $urandom_range(0, 9);
      wr = pick >= 5;
      rd = pick < 5 || pick == 9;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 1) a[0] = 1'b0;
        if (sz >= 2) a[1:0] = 2'b00;
      end
      pick = $urandom_range(0, 9);
      lat = pick < 5 ? 1 : pick < 7 ? 2 : pick < 8 ? 4 :
            pick < 9 ? TO : 0;
      access(wr, rd, sz, $urandom_range(0, 1), a, $urandom, lat,
             $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage access engine of the pipelined core.
- Consumes the memory-access controls produced in decode (write enable, load select, access size, unsigned flag) once they reach the M stage, together with the ALU-computed address and store data.
- Drives a single-outstanding req/ready data-memory port: byte-lane steering, write strobes, load alignment and sign/zero extension, misalignment detection and a bus timeout.
- Stalls the pipeline while a transaction is pending.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before the access is aborted with a fault; 0 disables the timeout.
- CNT_W, 5: timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- MemWriteM  in  1  store in M stage
- MemReadM  in  1  load in M stage (ResultSrc == 01)
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 treated as word
- MemUnsignedM  in  1  funct3[2]; zero-extend loads
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data (low bits significant)
- dmem_req  out  1  request valid (registered)
- dmem_we  out  1  write request
- dmem_addr  out  32  word-aligned address, {ALUResultM[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte write strobes; 0000 on reads
- dmem_ready  in  1  transaction complete; rdata valid on reads
- dmem_rdata  in  32  read word
- ReadDataM  out  32  aligned, extended load result (registered)
- StallM  out  1  hold F/D/E/M pipeline registers
- MisalignedM  out  1  misaligned-access exception, combinational
- AccessFaultM  out  1  timeout exception, one-cycle pulse in RESP

Behaviour:
- Reset: state IDLE, counter 0. dmem_req/we 0, dmem_addr/wdata 0, dmem_wstrb 0000, ReadDataM 0, AccessFaultM 0. Reset mid-WAIT drops dmem_req immediately; nothing is captured.
- access = MemReadM | MemWriteM. If both are asserted, treat as a load; dmem_we = 0.
- Misaligned condition: half with addr[0] = 1; word/11 with addr[1:0] != 0. Bytes are never misaligned.
- IDLE:
  - Misaligned access: MisalignedM = 1 this cycle, no request, StallM = 0, stay in IDLE.
  - Aligned access: StallM = 1. Register dmem_addr, dmem_we, dmem_wdata, dmem_wstrb; set dmem_req; go to WAIT.
- WAIT:
  - StallM = 1. dmem_req and all dmem_* outputs held stable. Counter increments each cycle.
  - dmem_ready = 1: drop dmem_req; on a load, capture the extracted result into ReadDataM; go to RESP.
  - Counter reaches TIMEOUT (TIMEOUT > 0) with ready still low: drop dmem_req; ReadDataM unchanged; set AccessFaultM; go to RESP. dmem_ready on the same cycle wins over the timeout.
- RESP: StallM = 0 and the pipeline advances this cycle. AccessFaultM shows its one-cycle pulse. Counter cleared. Go to IDLE; the access is never reissued.
- Latency: a 1-cycle memory gives IDLE → WAIT → RESP, i.e. 2 stall cycles and ReadDataM valid in RESP. Back-to-back accesses restart from IDLE.
- Store steering:
  - byte: wdata = {4{WriteDataM[7:0]}}, wstrb = 0001 << addr[1:0].
  - half: wdata = {2{WriteDataM[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - word: wdata = WriteDataM, wstrb = 1111.
- Load extract:
  - byte: lane addr[1:0]; half: lane addr[1].
  - Sign-extend unless MemUnsignedM = 1; MemUnsignedM is ignored for word.
  - Address and size are latched at issue, so extraction does not depend on M-stage inputs during WAIT.
- MisalignedM and AccessFaultM are never asserted together. ReadDataM changes only on load completion.

Test Plan:
- lb, addr 0x1002, rdata 0x80FF7F00 → req for exactly 1 WAIT cycle with ready; ReadDataM = 0xFFFFFFFF. Same access as lbu → 0x000000FF.
- lhu, addr 0x2002, rdata 0xBEEF1234 → ReadDataM = 0x0000BEEF. lh same → 0xFFFFBEEF.
- sb, addr 0x3003, data 0x000000A5 → dmem_wstrb = 1000, wdata = 0xA5A5A5A5, addr 0x3000, we = 1. sh at 0x3002 → wstrb = 1100.
- lw at 0x4002 → MisalignedM = 1 for one cycle, dmem_req never rises, StallM = 0.
- Word load with ready held low, TIMEOUT = 16 → StallM high for 17 cycles, then AccessFaultM one-cycle pulse, ReadDataM unchanged. Also cover ready on the 16th WAIT cycle → normal completion, no fault.
- rst asserted mid-WAIT → dmem_req = 0 and StallM = 0 asynchronously; the next aligned sw issues normally; back-to-back lw/sw each stall exactly 2 cycles with 1-cycle ready.
